// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
// The FSM state encoding and the BCD digit limits live here.
package bcd_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Request/result bundle of the serial BCD adder.
// The master requests an addition; the slave is the sequencer.
interface bcd_serial_adder_ctrl_if #(parameter int DIGITS = 3);

  logic                  start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Cin;
  logic [4*DIGITS-1:0]   Y;
  logic                  Cout;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, A, B, Cin,
    input  Y, Cout, busy, done, err
  );

  modport slave (
    input  start, A, B, Cin,
    output Y, Cout, busy, done, err
  );

endinterface

// File: rtl/bcd_serial_adder_ctrl_digit_adder.sv
// Single-digit BCD adder, purely combinational.
// A binary sum above nine gets the +6 correction and produces a decimal carry.
module bcd_digit_adder
  import bcd_serial_adder_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] s;

  always_comb begin
    s    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    y    = s[3:0];
    cout = 1'b0;
    if (s > {1'b0, BCD_MAX}) begin
      y    = s[3:0] + BCD_CORR;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD addition sequencer: one shared digit adder, LSD first,
// result and carry published together with a one-cycle done pulse.
module bcd_serial_adder_ctrl
  import bcd_serial_adder_ctrl_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  bcd_serial_adder_ctrl_if.slave    bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t          state;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    res;
  logic [W-1:0]    y_q;
  logic [CW-1:0]   cnt;
  logic            c;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic [3:0]      dsum;
  logic            dcarry;
  logic [W-1:0]    next_res;
  logic            digit_bad;

  bcd_digit_adder u_digit (
    .a    (op_a[3:0]),
    .b    (op_b[3:0]),
    .cin  (c),
    .y    (dsum),
    .cout (dcarry)
  );

  // Each new digit enters at the MSD end so the LSD ends up in [3:0] after DIGITS shifts.
  assign next_res  = (res >> 4) | (W'(dsum) << (W - 4));
  assign digit_bad = digit_invalid(op_a[3:0]) | digit_invalid(op_b[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      y_q    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (bus.start) begin
            op_a   <= bus.A;
            op_b   <= bus.B;
            c      <= bus.Cin;
            res    <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          res   <= next_res;
          op_a  <= op_a >> 4;
          op_b  <= op_b >> 4;
          c     <= dcarry;
          cnt   <= cnt + 1'b1;
          err_q <= err_q | digit_bad;
          // Outputs are published only here, so a partial sum is never visible.
          if (cnt == LAST) begin
            y_q    <= next_res;
            cout_q <= dcarry;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Y    = y_q;
  assign bus.Cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl (DIGITS=3) against a decimal
// arithmetic reference model; directed scenarios followed by random operations.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 3;
  localparam int W = 4 * DIGITS;
  localparam int TIMEOUT = 20;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: convert to integers, add in decimal, convert back.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                output logic [W-1:0] y, output logic cout, output logic err);
    int sa;
    int sb;
    int sum;
    sa = 0;
    sb = 0;
    err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      sa = sa * 10 + int'(a[4*i +: 4]);
      sb = sb * 10 + int'(b[4*i +: 4]);
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) err = 1'b1;
    end
    sum  = sa + sb + int'(cin);
    cout = (sum >= 1000);
    sum  = sum % 1000;
    y    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      y[4*i +: 4] = 4'(sum % 10);
      sum = sum / 10;
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Drives one start pulse; returns at the negedge just after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = cin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; lat=-1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat <= TIMEOUT) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (lat > TIMEOUT) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    checks += 5;
    if (bus.Y !== '0)      begin errors++; $display("[TB] FAIL reset_Y got %h want 000", bus.Y); end
    if (bus.Cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_Cout got %b want 0", bus.Cout); end
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    if (bus.err !== 1'b0)  begin errors++; $display("[TB] FAIL reset_err got %b want 0", bus.err); end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int bc;
    applyStimulus(12'h123, 12'h456, 1'b0);
    wait_done(lat, bc);
    checks += 5;
    if (lat != 3)          begin errors++; $display("[TB] FAIL basic_latency got %0d want 3", lat); end
    if (bc != 3)           begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 3", bc); end
    if (bus.Y !== 12'h579) begin errors++; $display("[TB] FAIL basic_Y got %h want 579", bus.Y); end
    if (bus.Cout !== 1'b0) begin errors++; $display("[TB] FAIL basic_Cout got %b want 0", bus.Cout); end
    if (bus.err !== 1'b0)  begin errors++; $display("[TB] FAIL basic_err got %b want 0", bus.err); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_overflow();
    int lat;
    int bc;
    applyStimulus(12'h999, 12'h001, 1'b0);
    wait_done(lat, bc);
    checks += 2;
    if (bus.Y !== 12'h000 || lat < 0) begin errors++; $display("[TB] FAIL wrap_Y got %h want 000", bus.Y); end
    if (bus.Cout !== 1'b1) begin errors++; $display("[TB] FAIL wrap_Cout got %b want 1", bus.Cout); end
    applyStimulus(12'h999, 12'h999, 1'b1);
    wait_done(lat, bc);
    checks += 2;
    if (bus.Y !== 12'h999 || lat < 0) begin errors++; $display("[TB] FAIL max_Y got %h want 999", bus.Y); end
    if (bus.Cout !== 1'b1) begin errors++; $display("[TB] FAIL max_Cout got %b want 1", bus.Cout); end
  endtask

  task automatic test_start_during_run();
    int lat;
    int bc;
    int dones;
    applyStimulus(12'h001, 12'h003, 1'b1);
    bus.A = 12'h777;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    bc = 0;
    while (bus.done !== 1'b1 && lat <= TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checks += 2;
    if (lat != 3)          begin errors++; $display("[TB] FAIL ignore_latency got %0d want 3", lat); end
    if (bus.Y !== 12'h005) begin errors++; $display("[TB] FAIL ignore_Y got %h want 005", bus.Y); end
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("[TB] FAIL ignore_extra_done got %0d want 0", dones); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    applyStimulus(12'h001, 12'h003, 1'b1);
    wait_done(lat, bc);
    checks++;
    if (bus.Y !== 12'h005) begin errors++; $display("[TB] FAIL b2b_first_Y got %h want 005", bus.Y); end
    bus.A = 12'h010;
    bus.B = 12'h004;
    bus.Cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat <= TIMEOUT) begin
      checks++;
      if (bus.Y !== 12'h005) begin errors++; $display("[TB] FAIL b2b_hold_Y got %h want 005", bus.Y); end
      @(negedge clk);
      lat++;
    end
    checks += 2;
    if (lat != 3)          begin errors++; $display("[TB] FAIL b2b_latency got %0d want 3", lat); end
    if (bus.Y !== 12'h014) begin errors++; $display("[TB] FAIL b2b_second_Y got %h want 014", bus.Y); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int bc;
    int dones;
    applyStimulus(12'h123, 12'h456, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (bus.Y !== '0)      begin errors++; $display("[TB] FAIL abort_Y got %h want 000", bus.Y); end
    if (bus.Cout !== 1'b0) begin errors++; $display("[TB] FAIL abort_Cout got %b want 0", bus.Cout); end
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", bus.done); end
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("[TB] FAIL abort_late_done got %0d want 0", dones); end
    applyStimulus(12'h250, 12'h250, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (bus.Y !== 12'h500 || lat != 3) begin errors++; $display("[TB] FAIL after_abort_Y got %h lat %0d want 500 lat 3", bus.Y, lat); end
  endtask

  task automatic test_invalid();
    int lat;
    int bc;
    applyStimulus(12'h1A3, 12'h001, 1'b0);
    wait_done(lat, bc);
    checks += 2;
    if (lat != 3)         begin errors++; $display("[TB] FAIL invalid_latency got %0d want 3", lat); end
    if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL invalid_err got %b want 1", bus.err); end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL invalid_err_hold got %b want 1", bus.err); end
    applyStimulus(12'h321, 12'h111, 1'b0);
    wait_done(lat, bc);
    checks += 2;
    if (bus.err !== 1'b0)  begin errors++; $display("[TB] FAIL valid_err_clear got %b want 0", bus.err); end
    if (bus.Y !== 12'h432) begin errors++; $display("[TB] FAIL valid_after_invalid_Y got %h want 432", bus.Y); end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] ey;
    logic         ec;
    logic         ee;
    int lat;
    int bc;
    for (int n = 0; n < 500; n++) begin
      a   = rand_bcd();
      b   = rand_bcd();
      cin = 1'($urandom_range(0, 1));
      model(a, b, cin, ey, ec, ee);
      applyStimulus(a, b, cin);
      wait_done(lat, bc);
      checks += 4;
      if (lat != 3)        begin errors++; $display("[TB] FAIL rand_latency got %0d want 3", lat); end
      if (bus.Y !== ey)    begin errors++; $display("[TB] FAIL rand_Y %h+%h+%b got %h want %h", a, b, cin, bus.Y, ey); end
      if (bus.Cout !== ec) begin errors++; $display("[TB] FAIL rand_Cout %h+%h+%b got %b want %b", a, b, cin, bus.Cout, ec); end
      if (bus.err !== ee)  begin errors++; $display("[TB] FAIL rand_err got %b want %b", bus.err, ee); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_invalid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
